// File: rtl/ldw_alu_pkg.sv
// Shared op-code fields and FSM state encoding for the sequential ALU.
// Legacy codes (op[4]=0) decode on op[2:0]; op[3] only matters for the shifts.
package ldw_alu_pkg;

    localparam logic [2:0] F_ADD = 3'b000;
    localparam logic [2:0] F_SUB = 3'b100;
    localparam logic [2:0] F_AND = 3'b001;
    localparam logic [2:0] F_OR  = 3'b101;
    localparam logic [2:0] F_XOR = 3'b010;
    localparam logic [2:0] F_LUI = 3'b110;
    localparam logic [2:0] F_SLL = 3'b011;
    localparam logic [2:0] F_SRX = 3'b111;

    localparam logic [3:0] OP_MUL   = 4'b0000;
    localparam logic [3:0] OP_MULHU = 4'b0001;
    localparam logic [3:0] OP_DIVU  = 4'b0010;
    localparam logic [3:0] OP_REMU  = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/ldw_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier and restoring divider.
// i_mode[1] selects divide, i_mode[0] selects the upper half (MULHU high word / REMU remainder).
module ldw_muldiv_iter
    import ldw_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_mode;
    logic             r_busy;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;

    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_trial = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_opnd};

    // r_hi/r_lo hold product high/low, or remainder/quotient, and stay put after the last step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_mode <= '0;
            r_busy <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_opnd <= '0;
        end else if (i_start) begin
            r_cnt  <= '0;
            r_mode <= i_mode;
            r_busy <= 1'b1;
            r_hi   <= '0;
            r_lo   <= i_mode[1] ? i_a : i_b;
            r_opnd <= i_mode[1] ? i_b : i_a;
        end else if (r_busy) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
                r_busy <= 1'b0;
            end
            if (r_mode[1]) begin
                r_hi <= w_trial[WIDTH] ? {r_hi[WIDTH-2:0], r_lo[WIDTH-1]} : w_trial[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], ~w_trial[WIDTH]};
            end else begin
                {r_hi, r_lo} <= {w_sum, r_lo[WIDTH-1:1]};
            end
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_busy && (r_cnt == LAST);
    assign o_result = r_mode[0] ? r_hi : r_lo;

endmodule

// File: rtl/ldw_seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops locally, mul/div via the iterative unit.
// Result of an iterative op is read straight from the sub-module's held registers.
module ldw_seq_alu
    import ldw_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             z,
    output logic             err
);

    state_t           r_state;
    logic [WIDTH-1:0] r_res;
    logic             r_err;
    logic             r_selMd;
    logic [WIDTH-1:0] w_res;
    logic             w_err;
    logic             w_multi;
    logic [SHW-1:0]   w_sh;
    logic             w_start;
    logic             w_mdBusy;
    logic             w_mdDone;
    logic [WIDTH-1:0] w_mdResult;
    logic [WIDTH-1:0] w_r;

    assign w_sh = a[SHW-1:0];

    always_comb begin
        w_res   = '1;
        w_err   = 1'b1;
        w_multi = 1'b0;
        if (!op[4]) begin
            w_err = 1'b0;
            case (op[2:0])
                F_ADD: w_res = a + b;
                F_SUB: w_res = a - b;
                F_AND: w_res = a & b;
                F_OR:  w_res = a | b;
                F_XOR: w_res = a ^ b;
                F_LUI: w_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
                F_SLL: begin
                    if (!op[3]) begin
                        w_res = b << w_sh;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                F_SRX: begin
                    if (op[3]) begin
                        w_res = $signed(b) >>> w_sh;
                    end else begin
                        w_res = b >> w_sh;
                    end
                end
                default: w_err = 1'b1;
            endcase
        end else begin
            case (op[3:0])
                OP_MUL, OP_MULHU: begin
                    w_multi = 1'b1;
                    w_err   = 1'b0;
                end
                OP_DIVU, OP_REMU: begin
                    // Divide by zero short-circuits to a faulting single-cycle result
                    if (b == '0) begin
                        w_res = op[0] ? a : '1;
                    end else begin
                        w_multi = 1'b1;
                        w_err   = 1'b0;
                    end
                end
                default: w_err = 1'b1;
            endcase
        end
    end

    assign w_start = (r_state == IDLE) && in_valid && w_multi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_res   <= '0;
            r_err   <= 1'b0;
            r_selMd <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (w_multi) begin
                            r_state <= BUSY;
                            r_selMd <= 1'b1;
                            r_err   <= 1'b0;
                        end else begin
                            r_state <= DONE;
                            r_selMd <= 1'b0;
                            r_res   <= w_res;
                            r_err   <= w_err;
                        end
                    end
                end
                BUSY: if (w_mdDone) r_state <= DONE;
                DONE: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    ldw_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_mode   (op[1:0]),
        .i_a      (a),
        .i_b      (b),
        .o_busy   (w_mdBusy),
        .o_done   (w_mdDone),
        .o_result (w_mdResult)
    );

    assign w_r       = r_selMd ? w_mdResult : r_res;
    assign r         = w_r;
    assign z         = ~|w_r;
    assign err       = r_err;
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);

endmodule

// File: tb/tb_ldw_seq_alu.sv
// Directed-vector bench for ldw_seq_alu at WIDTH=32 with hand-computed results.
module tb_ldw_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] r;
    logic        z;
    logic        err;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs [0:15];

    always #5 clk = ~clk;

    ldw_seq_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .z         (z),
        .err       (err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Offer one op, return the number of cycles until out_valid and whether in_ready rose meanwhile
    task automatic applyStimulus(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output int lat, output logic sawReady);
        @(negedge clk);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        sawReady = 1'b0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            if (in_ready) sawReady = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drainResult();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        int lat;
        logic sawReady;

        vecs = '{
            '{5'b00000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1},
            '{5'b01111, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000, 1'b0, 1},
            '{5'b00110, 32'h0000_0000, 32'h0000_1234, 32'h1234_0000, 1'b0, 1},
            '{5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33},
            '{5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33},
            '{5'b10010, 32'd100,       32'd7,         32'd14,        1'b0, 33},
            '{5'b10011, 32'd100,       32'd7,         32'd2,         1'b0, 33},
            '{5'b10010, 32'd100,       32'd0,         32'hFFFF_FFFF, 1'b1, 1},
            '{5'b10011, 32'd55,        32'd0,         32'd55,        1'b1, 1},
            '{5'b01100, 32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0, 1},
            '{5'b00011, 32'd4,         32'd1,         32'd16,        1'b0, 1},
            '{5'b00111, 32'd4,         32'h8000_0000, 32'h0800_0000, 1'b0, 1},
            '{5'b01011, 32'd4,         32'd1,         32'hFFFF_FFFF, 1'b1, 1},
            '{5'b10100, 32'd4,         32'd1,         32'hFFFF_FFFF, 1'b1, 1},
            '{5'b00101, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1},
            '{5'b11010, 32'h0000_1234, 32'h0000_5678, 32'h0000_1DB6, 1'b0, 33}
        };

        #1;
        checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_r", {32'd0, r}, 64'd0);
        checkOutput("rst_z", {63'd0, z}, 64'd1);
        checkOutput("rst_err", {63'd0, err}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            vec_t v;
            v = vecs[i];
            if (i == 15) begin
                v.r = 32'hFFFF_FFFF;
                v.err = 1'b1;
                v.lat = 1;
            end
            applyStimulus(v.op, v.a, v.b, lat, sawReady);
            checkOutput($sformatf("vec%0d_r", i), {32'd0, r}, {32'd0, v.r});
            checkOutput($sformatf("vec%0d_z", i), {63'd0, z}, {63'd0, (v.r == 32'd0)});
            checkOutput($sformatf("vec%0d_err", i), {63'd0, err}, {63'd0, v.err});
            checkOutput($sformatf("vec%0d_lat", i), 64'(lat), 64'(v.lat));
            checkOutput($sformatf("vec%0d_busy_ready", i), {63'd0, sawReady}, 64'd0);
            drainResult();
        end

        // Result must hold while the consumer stalls, and new offers are ignored until IDLE
        applyStimulus(5'b10010, 32'd100, 32'd7, lat, sawReady);
        op = 5'b00000;
        a = 32'd1;
        b = 32'd1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("hold%0d_r", k), {32'd0, r}, 64'd14);
            checkOutput($sformatf("hold%0d_in_ready", k), {63'd0, in_ready}, 64'd0);
            checkOutput($sformatf("hold%0d_out_valid", k), {63'd0, out_valid}, 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checkOutput("hold_release_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("hold_release_out_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checkOutput("hold_next_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("hold_next_r", {32'd0, r}, 64'd2);
        drainResult();

        // Reset in the middle of a divide discards it entirely
        @(negedge clk);
        op = 5'b10010;
        a = 32'd100;
        b = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("midrst_r", {32'd0, r}, 64'd0);
        checkOutput("midrst_z", {63'd0, z}, 64'd1);
        checkOutput("midrst_err", {63'd0, err}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("postrst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("postrst_in_ready", {63'd0, in_ready}, 64'd1);
        applyStimulus(5'b00000, 32'd2, 32'd3, lat, sawReady);
        checkOutput("postrst_add_r", {32'd0, r}, 64'd5);
        checkOutput("postrst_add_lat", 64'(lat), 64'd1);
        drainResult();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
